// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Request/result bundle between a requester and serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder, one full-adder slice, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    serial_adder_if.slave   bus
);
    localparam int               c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_aSr;
    logic [WIDTH-1:0]  r_bSr;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cOut;
    logic              r_busy;
    logic              r_done;
    logic [c_CW-1:0]   r_cnt;

    logic              w_s;
    logic              w_co;

    // The single full-adder slice, fed from the operand LSBs and the carry flop.
    assign w_s  = r_aSr[0] ^ r_bSr[0] ^ r_carry;
    assign w_co = (r_aSr[0] & r_bSr[0]) | (r_aSr[0] & r_carry) | (r_bSr[0] & r_carry);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_aSr   <= '0;
            r_bSr   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cOut  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_aSr   <= bus.a;
                        r_bSr   <= bus.b;
                        r_carry <= bus.c_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_aSr   <= {1'b0, r_aSr[WIDTH-1:1]};
                    r_bSr   <= {1'b0, r_bSr[WIDTH-1:1]};
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_cOut  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here; a new request waits for IDLE.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.c_out = r_cOut;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   nCmp;
    int   nFail;
    int   cyc;
    int   doneCyc;
    int   prevDone;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition: start accepted at the next edge, then WIDTH busy cycles and a done cycle.
    task automatic runAdd(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic hold,
                          input logic [W-1:0] altA, input logic [W-1:0] altB);
        logic [W:0] full;
        logic       prevC;
        int         busyN;
        full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.c_in  = ic;
        prevC     = bus.c_out;
        @(negedge clk);
        if (hold) begin
            bus.a = altA;
            bus.b = altB;
        end else begin
            bus.start = 1'b0;
            bus.a     = ~ia;
            bus.b     = ~ib;
            bus.c_in  = ~ic;
        end
        busyN = 0;
        for (int k = 1; k <= W; k++) begin
            if (bus.busy === 1'b1) busyN++;
            chk({tag, " done early"}, {31'd0, bus.done}, 32'd0);
            chk({tag, " c_out hold"}, {31'd0, bus.c_out}, {31'd0, prevC});
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, busyN, W);
        chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " busy off"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " sum"}, {24'd0, bus.sum}, {24'd0, full[W-1:0]});
        chk({tag, " c_out"}, {31'd0, bus.c_out}, {31'd0, full[W]});
        doneCyc = cyc;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        nCmp      = 0;
        nFail     = 0;
        cyc       = 0;
        doneCyc   = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset sum", {24'd0, bus.sum}, 32'd0);
        chk("reset c_out", {31'd0, bus.c_out}, 32'd0);
        reset = 1'b0;

        runAdd("5A+3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("5A+3C sum 96", {24'd0, bus.sum}, 32'h96);
        runAdd("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00);

        // Abort mid-addition with c_out still 1 from the previous result.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h3C;
        bus.c_in  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort sum", {24'd0, bus.sum}, 32'd0);
        chk("abort c_out", {31'd0, bus.c_out}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort no done", {31'd0, bus.done}, 32'd0);
        end
        reset = 1'b0;
        runAdd("01+01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("01+01 sum 02", {24'd0, bus.sum}, 32'h02);

        runAdd("FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        runAdd("00+00", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // start held high; new operands only take effect once back in IDLE.
        runAdd("10+20 held", 8'h10, 8'h20, 1'b0, 1'b1, 8'hAA, 8'h55);
        chk("held sum 30", {24'd0, bus.sum}, 32'h30);
        prevDone = doneCyc;
        runAdd("AA+55", 8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("held reaccept spacing", doneCyc - prevDone, W + 2);

        for (int n = 0; n < 3; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            prevDone = doneCyc;
            runAdd("b2b", ra, rb, rc, 1'b0, 8'h00, 8'h00);
            chk("b2b spacing", doneCyc - prevDone, W + 2);
        end

        @(negedge clk);
        chk("idle after done", {31'd0, bus.done}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial unsigned adder built around a single one-bit full-adder slice and a carry flip-flop.
- Sits directly upstream of the one-bit full-adder cell. It sequences operand bits LSB-first into that cell, registers the carry between cycles, and assembles the WIDTH-bit sum.
- Trades latency for area compared with the ripple-carry array.
- Used as the multi-cycle arithmetic stage in lab datapaths.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on clk rising edge.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- c_in  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: sum/c_out are valid.
- sum  output  WIDTH  result a+b+c_in modulo 2^WIDTH.
- c_out  output  1  final carry-out (bit WIDTH of a+b+c_in).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (asynchronous, effective immediately):
  - state=IDLE; busy=0, done=0, sum=0, c_out=0.
  - Operand shift registers, carry register and bit counter all cleared.
- States: IDLE, ADD, DONE. The state register is binary-encoded.
- IDLE:
  - start=1 at a clock edge: load a and b into shift registers, carry_q<=c_in, cnt<=0, go to ADD.
  - start=0: remain in IDLE. sum and c_out hold their last values.
- ADD (busy=1), each cycle:
  - Full-adder slice computes s = a_sr[0]^b_sr[0]^carry_q and co = majority(a_sr[0], b_sr[0], carry_q).
  - At the edge: a_sr and b_sr shift right by 1 (zero fill); sum shifts right with s entering bit WIDTH-1; carry_q<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: c_out<=co, go to DONE.
  - Exactly WIDTH cycles are spent in ADD.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally go to IDLE.
- Timing: start sampled at edge E0 means busy is high for cycles E0..E0+WIDTH, and done is high in the cycle after edge E0+WIDTH. The earliest next accepted start is at edge E0+WIDTH+2.
- sum is not valid during ADD (it holds partial, shifting data). It is valid from the done cycle until the next accepted start.
- c_out updates only at the final ADD edge. It holds its value otherwise, and does not change during the next ADD until that addition's final edge.
- start is ignored in ADD and DONE: no restart, and operands are not reloaded.
- Changes to a, b or c_in after capture have no effect on the addition in progress.
- Reset mid-operation aborts the addition: no done pulse, and all outputs return to 0.
- cnt width is clog2(WIDTH)+1 bits; no wrap occurs within a legal operation.
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, single start pulse -> busy high 8 cycles; done pulse 9 cycles after the start edge; sum=0x96, c_out=0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Carry ripples through all 8 serial steps.
- a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1. Then a=0x00, b=0x00, c_in=0 -> sum=0x00, c_out=0. c_out holds 1 until the final edge of the second addition.
- Start a=0x10, b=0x20, then hold start=1 and change a to 0xAA, b to 0x55 during ADD and DONE -> result 0x30, c_out=0; exactly one done pulse; the second operand pair is accepted only on return to IDLE.
- Assert reset during ADD cycle 4 of a=0xC3, b=0x3C -> outputs 0 immediately (asynchronous); no done pulse. A subsequent start with a=0x01, b=0x01 -> sum=0x02.
- Back-to-back: start asserted on the first IDLE cycle after each done, for 3 random operand sets -> each sum/c_out matches a+b+c_in against the reference model; done spacing is WIDTH+2 cycles.
